// File: rtl/array_streamer.sv
// array_streamer: snapshots a packed array on start and streams its elements
// over valid/ready, reporting the OR of everything emitted with a done pulse.
module array_streamer #(
  parameter int ELEMENTS = 4,
  parameter int WIDTH    = 8,
  localparam int IW      = $clog2(ELEMENTS)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [ELEMENTS*WIDTH-1:0] array,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          element,
  output logic [IW-1:0]             index,
  output logic                      last,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH-1:0]          result
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(ELEMENTS - 1);

  state_t                    r_state;
  logic [ELEMENTS*WIDTH-1:0] r_snap;
  logic [IW-1:0]             r_idx;
  logic [WIDTH-1:0]          r_acc;
  logic [WIDTH-1:0]          r_result;
  logic                      r_valid;
  logic                      r_busy;
  logic                      r_done;

  logic [WIDTH-1:0]          w_elem;
  logic                      w_last;

  assign w_elem = r_snap[r_idx*WIDTH +: WIDTH];
  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_snap   <= '0;
      r_idx    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_snap   <= array;
            r_acc    <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= STREAM;
          end
        end
        STREAM: begin
          if (out_ready) begin
            r_acc <= r_acc | w_elem;
            if (w_last) begin
              // result is published together with the done pulse
              r_result <= r_acc | w_elem;
              r_valid  <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_valid;
  assign element   = w_elem;
  assign index     = r_idx;
  assign last      = r_valid & w_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;

endmodule

// File: tb/tb_array_streamer.sv
// tb_array_streamer: directed vector table plus reset and
// back-to-back sequences for array_streamer.
module tb_array_streamer;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [31:0] array;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  element;
  logic [1:0]  index;
  logic        last;
  logic        busy;
  logic        done;
  logic [7:0]  result;

  int n_tests = 0;
  int n_fail  = 0;

  array_streamer #(.ELEMENTS(4), .WIDTH(8)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .array     (array),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .element   (element),
    .index     (index),
    .last      (last),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        st;
    logic        rdy;
    logic [31:0] arr;
    logic        v;
    logic [1:0]  idx;
    logic [7:0]  el;
    logic        lst;
    logic        bsy;
    logic        dn;
    logic [7:0]  res;
  } vec_t;

  localparam logic [31:0] A  = 32'h8872_11AA;
  localparam logic [31:0] FF = 32'hFFFF_FFFF;
  localparam logic [31:0] B  = 32'h0102_0408;

  vec_t tv[22];

  function automatic vec_t mk(logic st, logic rdy, logic [31:0] arr,
                              logic v, logic [1:0] idx, logic [7:0] el,
                              logic lst, logic bsy, logic dn,
                              logic [7:0] res);
    vec_t t;
    t.st = st; t.rdy = rdy; t.arr = arr;
    t.v = v; t.idx = idx; t.el = el; t.lst = lst;
    t.bsy = bsy; t.dn = dn; t.res = res;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] src;
    int          ph;
    logic [7:0]  exp_res;

    // test 1: basic stream
    tv[0]  = mk(1, 1, A,  1, 0, 8'hAA, 0, 1, 0, 8'h00);
    tv[1]  = mk(0, 1, A,  1, 1, 8'h11, 0, 1, 0, 8'h00);
    tv[2]  = mk(0, 1, A,  1, 2, 8'h72, 0, 1, 0, 8'h00);
    tv[3]  = mk(0, 1, A,  1, 3, 8'h88, 1, 1, 0, 8'h00);
    tv[4]  = mk(0, 1, A,  0, 0, 8'h00, 0, 1, 1, 8'hFB);
    tv[5]  = mk(0, 1, A,  0, 0, 8'h00, 0, 0, 0, 8'hFB);
    // test 2: backpressure at index 1
    tv[6]  = mk(1, 1, A,  1, 0, 8'hAA, 0, 1, 0, 8'h00);
    tv[7]  = mk(0, 1, A,  1, 1, 8'h11, 0, 1, 0, 8'h00);
    tv[8]  = mk(0, 0, A,  1, 1, 8'h11, 0, 1, 0, 8'h00);
    tv[9]  = mk(0, 0, A,  1, 1, 8'h11, 0, 1, 0, 8'h00);
    tv[10] = mk(0, 0, A,  1, 1, 8'h11, 0, 1, 0, 8'h00);
    tv[11] = mk(0, 1, A,  1, 2, 8'h72, 0, 1, 0, 8'h00);
    tv[12] = mk(0, 1, A,  1, 3, 8'h88, 1, 1, 0, 8'h00);
    tv[13] = mk(0, 1, A,  0, 0, 8'h00, 0, 1, 1, 8'hFB);
    tv[14] = mk(0, 1, A,  0, 0, 8'h00, 0, 0, 0, 8'hFB);
    // test 3: snapshot isolation, start ignored while busy
    tv[15] = mk(1, 1, A,  1, 0, 8'hAA, 0, 1, 0, 8'h00);
    tv[16] = mk(1, 1, FF, 1, 1, 8'h11, 0, 1, 0, 8'h00);
    tv[17] = mk(0, 1, FF, 1, 2, 8'h72, 0, 1, 0, 8'h00);
    tv[18] = mk(1, 1, FF, 1, 3, 8'h88, 1, 1, 0, 8'h00);
    tv[19] = mk(1, 1, FF, 0, 0, 8'h00, 0, 1, 1, 8'hFB);
    tv[20] = mk(1, 1, FF, 0, 0, 8'h00, 0, 0, 0, 8'hFB);
    tv[21] = mk(0, 1, FF, 0, 0, 8'h00, 0, 0, 0, 8'hFB);

    reset_n   = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    array     = A;
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy",  32'(busy),      0);
    chk("rst_done",  32'(done),      0);
    chk("rst_last",  32'(last),      0);
    chk("rst_index", 32'(index),     0);
    chk("rst_elem",  32'(element),   0);
    chk("rst_res",   32'(result),    0);
    #10 reset_n = 1'b1;
    step();

    for (int i = 0; i < 22; i++) begin
      start     = tv[i].st;
      out_ready = tv[i].rdy;
      array     = tv[i].arr;
      step();
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tv[i].v));
      chk($sformatf("v%0d_busy", i),  32'(busy),      32'(tv[i].bsy));
      chk($sformatf("v%0d_done", i),  32'(done),      32'(tv[i].dn));
      chk($sformatf("v%0d_last", i),  32'(last),      32'(tv[i].lst));
      chk($sformatf("v%0d_res", i),   32'(result),    32'(tv[i].res));
      if (tv[i].v) begin
        chk($sformatf("v%0d_idx", i),  32'(index),   32'(tv[i].idx));
        chk($sformatf("v%0d_elem", i), 32'(element), 32'(tv[i].el));
      end
    end

    // test 4: asynchronous reset while index==2
    start     = 1'b1;
    out_ready = 1'b1;
    array     = A;
    step();
    start = 1'b0;
    step();
    step();
    chk("r4_pre_idx", 32'(index), 2);
    #2 reset_n = 1'b0;
    #1;
    chk("r4_valid", 32'(out_valid), 0);
    chk("r4_busy",  32'(busy),      0);
    chk("r4_done",  32'(done),      0);
    chk("r4_index", 32'(index),     0);
    chk("r4_res",   32'(result),    0);
    chk("r4_elem",  32'(element),   0);
    #3 reset_n = 1'b1;
    step();
    chk("r4_idle_busy", 32'(busy), 0);
    start = 1'b1;
    array = 32'h0000_0000;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("z%0d_valid", k), 32'(out_valid), 1);
      chk($sformatf("z%0d_idx", k),   32'(index),     32'(k));
      chk($sformatf("z%0d_elem", k),  32'(element),   0);
      step();
    end
    chk("z_done", 32'(done),   1);
    chk("z_res",  32'(result), 0);
    step();

    // test 5: start held high, period ELEMENTS+2
    start = 1'b1;
    array = A;
    for (int n = 0; n < 12; n++) begin
      step();
      if (n == 1) array = B;
      ph  = n % 6;
      src = (n < 6) ? A : B;
      if (n < 4)       exp_res = 8'h00;
      else if (n < 6)  exp_res = 8'hFB;
      else if (n < 10) exp_res = 8'h00;
      else             exp_res = 8'h0F;
      chk($sformatf("b%0d_valid", n), 32'(out_valid), 32'(ph < 4));
      chk($sformatf("b%0d_done", n),  32'(done),      32'(ph == 4));
      chk($sformatf("b%0d_busy", n),  32'(busy),      32'(ph < 5));
      chk($sformatf("b%0d_res", n),   32'(result),    32'(exp_res));
      if (ph < 4) begin
        chk($sformatf("b%0d_idx", n),  32'(index), 32'(ph));
        chk($sformatf("b%0d_elem", n), 32'(element),
            32'(src[ph*8 +: 8]));
      end
    end
    start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
